// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity mode codes, default
// oversampling ratio (also used by the tick generator and transmitter), and a
// 2-of-3 majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned DEFAULT_OSR = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level, reset value 1 (idle line).
// Ports: clk, reset (sync active-low), d (async in), q (synchronised out).
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (DATA_BITS, PARITY, STOP_BITS, OSR) with
// false-start rejection, valid/ready output, parity/framing flags and an
// overrun pulse. Optional macro UART_RX_MAJORITY_EN enables 2-of-3 majority
// sampling around each decision point.
// Ports: clk, reset (sync active-low), tick (OSR x baud strobe), rx (async
// serial in), data_out/valid/ready (word handshake), parity_err, frame_err,
// overrun (one-clk pulse when a completed frame is dropped).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned OSR       = DEFAULT_OSR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr, perr_nxt;
    logic                 ferr, ferr_nxt;
    logic                 armed, armed_nxt;
    logic                 push, push_nxt;
    logic [CW-1:0]        dec_c;
    logic                 decide_c;
    logic                 sample_c;

    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt, perr_o_nxt, ferr_o_nxt, overrun_nxt;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decision is one tick later than the single-sample build; majority of
    // the two preceding ticks and the decision tick.
    localparam int unsigned START_DEC = OSR / 2;

    logic hist_a, hist_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_a <= 1'b1;
            hist_b <= 1'b1;
        end else if (tick) begin
            if (cnt == dec_c - CW'(2)) hist_a <= rx_s;
            if (cnt == dec_c - CW'(1)) hist_b <= rx_s;
        end
    end

    assign sample_c = maj3(hist_a, hist_b, rx_s);
`else
    localparam int unsigned START_DEC = OSR / 2 - 1;

    assign sample_c = rx_s;
`endif

    // Decision tick: mid-bit for the start confirm, end of period otherwise.
    assign dec_c    = (state == ST_START) ? CW'(START_DEC) : CW'(OSR - 1);
    assign decide_c = tick && (cnt == dec_c);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            armed   <= 1'b1;
            push    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            perr    <= perr_nxt;
            ferr    <= ferr_nxt;
            armed   <= armed_nxt;
            push    <= push_nxt;
        end
    end

    // Next-state and frame datapath
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        perr_nxt    = perr;
        ferr_nxt    = ferr;
        armed_nxt   = armed;
        push_nxt    = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = '0;
                    // After a break, the line must be seen high before re-arming.
                    if (rx_s) armed_nxt = 1'b1;
                    if (!rx_s && armed) begin
                        state_nxt = ST_START;
                        perr_nxt  = 1'b0;
                        ferr_nxt  = 1'b0;
                    end
                end
                ST_START: begin
                    cnt_nxt = cnt + CW'(1);
                    if (decide_c) begin
                        cnt_nxt     = '0;
                        bit_cnt_nxt = '0;
                        state_nxt   = sample_c ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    cnt_nxt = cnt + CW'(1);
                    if (decide_c) begin
                        cnt_nxt     = '0;
                        shreg_nxt   = {sample_c, shreg[DATA_BITS-1:1]};
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_nxt = cnt + CW'(1);
                    if (decide_c) begin
                        cnt_nxt   = '0;
                        perr_nxt  = ((^shreg) ^ sample_c) != (PARITY == PAR_ODD);
                        state_nxt = ST_STOP;
                    end
                end
                ST_STOP: begin
                    cnt_nxt = cnt + CW'(1);
                    if (decide_c) begin
                        cnt_nxt     = '0;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        if (!sample_c) ferr_nxt = 1'b1;
                        if (bit_cnt == BW'(STOP_BITS - 1)) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = ST_IDLE;
                            push_nxt    = 1'b1;
                            if (ferr || !sample_c) armed_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output next values: push on the clk after the last stop sample
    always_comb begin
        data_nxt    = data_out;
        perr_o_nxt  = parity_err;
        ferr_o_nxt  = frame_err;
        valid_nxt   = valid;
        overrun_nxt = 1'b0;
        if (valid && ready) valid_nxt = 1'b0;
        if (push) begin
            if (!valid || ready) begin
                data_nxt   = shreg;
                perr_o_nxt = perr;
                ferr_o_nxt = ferr;
                valid_nxt  = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_out   <= data_nxt;
            valid      <= valid_nxt;
            parity_err <= perr_o_nxt;
            frame_err  <= ferr_o_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 lane, even-parity lane, 9-bit/2-stop lane.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int BIT_CLK = 64; // 16 ticks per bit, one tick every 4 clk

    logic clk = 1'b0;
    logic reset;
    logic tick = 1'b0;
    logic rx0, rx1, rx2;
    logic ready0, ready1, ready2;
    logic [7:0] data_out0, data_out1;
    logic [8:0] data_out2;
    logic valid0, valid1, valid2;
    logic parity_err0, parity_err1, parity_err2;
    logic frame_err0, frame_err1, frame_err2;
    logic overrun0, overrun1, overrun2;

    int total = 0;
    int bad   = 0;

    int vcount0 = 0, vcount1 = 0, vcount2 = 0, ocount0 = 0;
    logic [8:0] ld0, ld1, ld2;
    logic lp0, lp1, lf0, lf2;
    int snap_v, snap_o;

    uart_rx_param #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OSR(16)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx0), .data_out(data_out0),
        .valid(valid0), .ready(ready0), .parity_err(parity_err0),
        .frame_err(frame_err0), .overrun(overrun0));

    uart_rx_param #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .OSR(16)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx1), .data_out(data_out1),
        .valid(valid1), .ready(ready1), .parity_err(parity_err1),
        .frame_err(frame_err1), .overrun(overrun1));

    uart_rx_param #(.DATA_BITS(9), .PARITY(PAR_NONE), .STOP_BITS(2), .OSR(16)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx2), .data_out(data_out2),
        .valid(valid2), .ready(ready2), .parity_err(parity_err2),
        .frame_err(frame_err2), .overrun(overrun2));

    always #5 clk = ~clk;

    // Tick strobe: one clk high out of every four
    initial begin
        logic [1:0] tdiv;
        tdiv = 2'd0;
        forever begin
            @(negedge clk);
            tick = (tdiv == 2'd3);
            tdiv = tdiv + 2'd1;
        end
    end

    // Record what each lane delivers
    always @(negedge clk) begin
        if (valid0) begin vcount0 <= vcount0 + 1; ld0 <= {1'b0, data_out0}; lp0 <= parity_err0; lf0 <= frame_err0; end
        if (valid1) begin vcount1 <= vcount1 + 1; ld1 <= {1'b0, data_out1}; lp1 <= parity_err1; end
        if (valid2) begin vcount2 <= vcount2 + 1; ld2 <= data_out2; lf2 <= frame_err2; end
        if (overrun0) ocount0 <= ocount0 + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int lane, input logic v);
        case (lane)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic hold_bits(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    // par < 0: no parity bit. stops[i] is stop bit i. idle_val is left on the line.
    task automatic send(input int lane, input logic [8:0] word, input int nbits,
                        input int par, input logic [1:0] stops, input int nstop,
                        input logic idle_val);
        drive(lane, 1'b0);
        hold_bits(1);
        for (int i = 0; i < nbits; i++) begin
            drive(lane, word[i]);
            hold_bits(1);
        end
        if (par >= 0) begin
            drive(lane, par[0]);
            hold_bits(1);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(lane, stops[i]);
            hold_bits(1);
        end
        drive(lane, idle_val);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        repeat (6) @(negedge clk);

        // Reset state
        check("rst_valid0", 16'(valid0), 16'h0);
        check("rst_data0", 16'(data_out0), 16'h0);
        check("rst_flags0", 16'({parity_err0, frame_err0, overrun0}), 16'h0);
        check("rst_valid12", 16'({valid1, valid2}), 16'h0);
        reset = 1'b1;
        hold_bits(2);

        // 8N1 0xA5
        snap_v = vcount0;
        send(0, 9'h0A5, 8, -1, 2'b11, 1, 1'b1);
        check("a5_vcycles", 16'(vcount0 - snap_v), 16'd1);
        check("a5_data", 16'(ld0), 16'h0A5);
        check("a5_flags", 16'({lp0, lf0}), 16'h0);
        hold_bits(1);

        // False start of 4 ticks
        snap_v = vcount0;
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        rx0 = 1'b1;
        hold_bits(3);
        check("glitch_novalid", 16'(vcount0 - snap_v), 16'd0);
        check("glitch_idle", 16'(dut0.state), 16'(ST_IDLE));
        send(0, 9'h03C, 8, -1, 2'b11, 1, 1'b1);
        check("3c_vcycles", 16'(vcount0 - snap_v), 16'd1);
        check("3c_data", 16'(ld0), 16'h03C);
        hold_bits(1);

        // Even parity lane: 0x07 with wrong then correct parity
        send(1, 9'h007, 8, 0, 2'b11, 1, 1'b1);
        check("par_bad_data", 16'(ld1), 16'h007);
        check("par_bad_flag", 16'(lp1), 16'h1);
        hold_bits(1);
        snap_v = vcount1;
        send(1, 9'h007, 8, 1, 2'b11, 1, 1'b1);
        check("par_ok_count", 16'(vcount1 - snap_v), 16'd1);
        check("par_ok_flag", 16'(lp1), 16'h0);
        hold_bits(1);

        // Framing error followed by a held-low break
        send(0, 9'h055, 8, -1, 2'b00, 1, 1'b0);
        check("fe_data", 16'(ld0), 16'h055);
        check("fe_flag", 16'(lf0), 16'h1);
        snap_v = vcount0;
        hold_bits(4);
        check("break_novalid", 16'(vcount0 - snap_v), 16'd0);
        rx0 = 1'b1;
        hold_bits(2);
        check("break_still_none", 16'(vcount0 - snap_v), 16'd0);
        send(0, 9'h05A, 8, -1, 2'b11, 1, 1'b1);
        check("after_break_data", 16'(ld0), 16'h05A);
        check("after_break_fe", 16'(lf0), 16'h0);
        hold_bits(1);

        // Overrun with ready low
        ready0 = 1'b0;
        snap_o = ocount0;
        send(0, 9'h011, 8, -1, 2'b11, 1, 1'b1);
        hold_bits(1);
        send(0, 9'h022, 8, -1, 2'b11, 1, 1'b1);
        hold_bits(1);
        check("ovr_held_data", 16'(data_out0), 16'h011);
        check("ovr_held_valid", 16'(valid0), 16'h1);
        check("ovr_pulses", 16'(ocount0 - snap_o), 16'd1);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        @(negedge clk);
        check("ovr_drain_valid", 16'(valid0), 16'h0);
        ready0 = 1'b1;
        hold_bits(1);

        // Reset during data bit 4
        snap_v = vcount0;
        rx0 = 1'b0;
        hold_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx0 = i[0];
            hold_bits(1);
        end
        rx0 = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_data", 16'(data_out0), 16'h0);
        check("midrst_vf", 16'({valid0, parity_err0, frame_err0, overrun0}), 16'h0);
        reset = 1'b1;
        hold_bits(3);
        check("midrst_novalid", 16'(vcount0 - snap_v), 16'd0);
        check("midrst_idle", 16'(dut0.state), 16'(ST_IDLE));
        send(0, 9'h0F0, 8, -1, 2'b11, 1, 1'b1);
        check("f0_count", 16'(vcount0 - snap_v), 16'd1);
        check("f0_data", 16'(ld0), 16'h0F0);
        hold_bits(1);

        // 9-bit, 2 stop bits
        snap_v = vcount2;
        send(2, 9'h1AB, 9, -1, 2'b11, 2, 1'b1);
        check("w9_count", 16'(vcount2 - snap_v), 16'd1);
        check("w9_data", 16'(ld2), 16'h1AB);
        check("w9_fe", 16'(lf2), 16'h0);
        hold_bits(1);
        send(2, 9'h0C3, 9, -1, 2'b01, 2, 1'b1);
        check("w9_stop2_data", 16'(ld2), 16'h0C3);
        check("w9_stop2_fe", 16'(lf2), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
